rtc_reg_arbiter: RTL and testbench

- Owns the RTC register bank: a 56-bit seconds counter, a 56-bit alarm and a control/status byte.
- Arbitrates between two sources of updates: the once-per-second tick from the prescaler, and host write frames delivered by the SPI frame FSM (buf_dv plus the 64-bit write buffer).
- Publishes a coherent 64-bit read snapshot, which the SPI FSM loads when it starts a read frame.

---
 rtl/rtc_pkg.sv | 24 ++
 rtl/rtc_pulse_edge.sv | 20 ++
 rtl/rtc_reg_arbiter.sv | 155 +++++++++++++++
 tb/tb_rtc_reg_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC register bank: frame geometry, host select
// codes, status-byte bit positions and the arbiter FSM encoding.
package rtc_pkg;

    localparam int FRAME_W = 64;
    localparam int TIME_W  = FRAME_W - 8;

    localparam logic [7:0] SEL_TIME  = 8'h00;
    localparam logic [7:0] SEL_ALARM = 8'h01;
    localparam logic [7:0] SEL_CTRL  = 8'h02;

    localparam int ST_RUN  = 0;
    localparam int ST_AEN  = 1;
    localparam int ST_IRQ  = 2;
    localparam int ST_LOST = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_TICK    = 2'd2,
        S_PUBLISH = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rtc_pulse_edge.sv
// Rising-edge detector: remembers last cycle's level and flags a 0->1 change
// combinationally, so the pending flag can latch on the very edge that samples it.
module rtc_pulse_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev;

    // Remember the level seen at the previous edge
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= sig;
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/rtc_reg_arbiter.sv
// RTC register bank with a small arbiter that serialises host write frames and
// once-per-second ticks, then republishes a coherent {status, time} snapshot.
import rtc_pkg::*;

module rtc_reg_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int TW    = 56
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   buf_dv,
    input  logic [DEPTH*WIDTH-1:0] wr_buf,
    output logic [DEPTH*WIDTH-1:0] rd_buf,
    output logic                   irq,
    output logic                   busy
);

    localparam int FW = DEPTH * WIDTH;

    arb_state_t state, next_state;

    logic [TW-1:0] time_cnt;
    logic [TW-1:0] alarm;
    logic          run;
    logic          alarm_en;
    logic          irq_q;
    logic          tick_lost;
    logic          pend_tick;
    logic          pend_wr;
    logic [FW-1:0] wr_hold;

    logic          dv_rise;
    logic [7:0]    sel;
    logic [TW-1:0] value;
    logic [TW-1:0] time_inc;
    logic          in_write;
    logic          in_tick;
    logic          time_write;
    logic          ctrl_write;
    logic          tick_take;
    logic          tick_clear;
    logic [7:0]    status;

    rtc_pulse_edge u_dv_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (buf_dv),
        .rise (dv_rise)
    );

    assign sel        = wr_hold[FW-1 -: 8];
    assign value      = wr_hold[TW-1:0];
    assign time_inc   = time_cnt + TW'(1);
    assign in_write   = (state == S_WRITE);
    assign in_tick    = (state == S_TICK);
    assign time_write = in_write && (sel == SEL_TIME);
    assign ctrl_write = in_write && (sel == SEL_CTRL);
    assign tick_take  = tick && run;
    // An absolute time set supersedes a queued tick, so it clears it like a serviced tick
    assign tick_clear = in_tick || time_write;

    assign irq  = irq_q;
    assign busy = (state != S_IDLE);

    // Assemble the status byte from the individual control/status bits
    always_comb begin
        status          = '0;
        status[ST_RUN]  = run;
        status[ST_AEN]  = alarm_en;
        status[ST_IRQ]  = irq_q;
        status[ST_LOST] = tick_lost;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state: host writes win over ticks; every service ends with a publish
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (pend_wr)        next_state = S_WRITE;
                else if (pend_tick) next_state = S_TICK;
            end
            S_WRITE:   next_state = S_PUBLISH;
            S_TICK:    next_state = S_PUBLISH;
            S_PUBLISH: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Event latching runs every cycle regardless of state; new events win over clears
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_tick <= 1'b0;
            pend_wr   <= 1'b0;
            wr_hold   <= '0;
        end else begin
            if (tick_take)       pend_tick <= 1'b1;
            else if (tick_clear) pend_tick <= 1'b0;

            if (dv_rise)       pend_wr <= 1'b1;
            else if (in_write) pend_wr <= 1'b0;

            if (dv_rise) wr_hold <= wr_buf;
        end
    end

    // Register bank updates applied on the exit edge of WRITE or TICK
    always_ff @(posedge clk) begin
        if (rst) begin
            time_cnt  <= '0;
            alarm     <= '1;
            run       <= 1'b0;
            alarm_en  <= 1'b0;
            irq_q     <= 1'b0;
            tick_lost <= 1'b0;
        end else begin
            if (time_write)
                time_cnt <= value;
            else if (in_tick)
                time_cnt <= time_inc;

            if (in_write && (sel == SEL_ALARM))
                alarm <= value;

            if (ctrl_write) begin
                run      <= value[ST_RUN];
                alarm_en <= value[ST_AEN];
            end

            if (ctrl_write && value[ST_IRQ])
                irq_q <= 1'b0;
            else if (in_tick && alarm_en && (time_inc == alarm))
                irq_q <= 1'b1;

            if (tick_take && pend_tick && !tick_clear)
                tick_lost <= 1'b1;
            else if (ctrl_write && value[ST_LOST])
                tick_lost <= 1'b0;
        end
    end

    // Snapshot only in PUBLISH so a reader never sees a half-applied update
    always_ff @(posedge clk) begin
        if (rst)                     rd_buf <= '0;
        else if (state == S_PUBLISH) rd_buf <= {status, time_cnt};
    end

endmodule

// File: tb/tb_rtc_reg_arbiter.sv
// Self-checking bench for rtc_reg_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to an event model.
module tb_rtc_reg_arbiter;

    localparam logic [7:0] SEL_TIME  = 8'h00;
    localparam logic [7:0] SEL_ALARM = 8'h01;
    localparam logic [7:0] SEL_CTRL  = 8'h02;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        buf_dv;
    logic [63:0] wr_buf;
    logic [63:0] rd_buf;
    logic        irq;
    logic        busy;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit          model_live = 0;
    logic [55:0] m_time;
    logic [55:0] m_alarm;
    bit          m_run, m_aen, m_irq, m_lost;
    bit          m_ptick, m_pwr, m_prev;
    logic [63:0] m_hold;
    logic [63:0] m_rd;
    int          m_phase;
    int          m_kind;

    rtc_reg_arbiter #(.DEPTH(8), .WIDTH(8), .TW(56)) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .buf_dv (buf_dv),
        .wr_buf (wr_buf),
        .rd_buf (rd_buf),
        .irq    (irq),
        .busy   (busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    // One clock edge of the model: a service takes one cycle to start, applies
    // on the next, and the snapshot is republished on the one after that.
    task automatic modelStep();
        bit          o_run, o_ptick, o_pwr, rise, clr_tick;
        logic [63:0] o_hold;
        logic [7:0]  s;
        logic [55:0] v;
        if (rst) begin
            model_live = 1;
            m_time = '0; m_alarm = '1;
            m_run = 0; m_aen = 0; m_irq = 0; m_lost = 0;
            m_ptick = 0; m_pwr = 0; m_prev = 0;
            m_hold = '0; m_rd = '0; m_phase = 0; m_kind = 0;
            return;
        end
        if (!model_live) return;
        o_run = m_run; o_ptick = m_ptick; o_pwr = m_pwr; o_hold = m_hold;
        rise = buf_dv && !m_prev;
        m_prev = buf_dv;
        clr_tick = 0;
        case (m_phase)
            0: begin
                if (o_pwr) begin m_phase = 1; m_kind = 0; end
                else if (o_ptick) begin m_phase = 1; m_kind = 1; end
            end
            1: begin
                if (m_kind == 0) begin
                    m_pwr = 0;
                    s = o_hold[63:56];
                    v = o_hold[55:0];
                    if (s == SEL_TIME) begin
                        m_time = v;
                        clr_tick = 1;
                    end else if (s == SEL_ALARM) begin
                        m_alarm = v;
                    end else if (s == SEL_CTRL) begin
                        m_run = v[0];
                        m_aen = v[1];
                        if (v[2]) m_irq = 0;
                        if (v[3]) m_lost = 0;
                    end
                end else begin
                    m_time = m_time + 56'd1;
                    clr_tick = 1;
                    if (m_aen && m_time == m_alarm) m_irq = 1;
                end
                m_phase = 2;
            end
            default: begin
                m_rd = {4'b0, m_lost, m_irq, m_aen, m_run, m_time};
                m_phase = 0;
            end
        endcase
        if (clr_tick) m_ptick = 0;
        if (o_run && tick) begin
            if (o_ptick && !clr_tick) m_lost = 1;
            m_ptick = 1;
        end
        if (rise) begin
            m_pwr = 1;
            m_hold = wr_buf;
        end
    endtask

    // Advance the model on every active edge
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Compare DUT outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                checkOutput("rd_buf", rd_buf, m_rd);
                checkOutput("irq", {63'b0, irq}, {63'b0, m_irq});
                checkOutput("busy", {63'b0, busy}, {63'b0, m_phase != 0});
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic [55:0] v);
        buf_dv = 1'b1;
        wr_buf = {s, v};
        @(negedge clk);
        buf_dv = 1'b0;
    endtask

    task automatic tickOnce();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        int          busy_cnt;
        int          r;
        logic [55:0] rv;
        rst = 1'b1; tick = 1'b0; buf_dv = 1'b0; wr_buf = '0;
        waitCycles(3);
        rst = 1'b0;
        checkOutput("reset_rd", rd_buf, 64'h0);
        checkOutput("reset_irq", {63'b0, irq}, 64'h0);
        checkOutput("reset_busy", {63'b0, busy}, 64'h0);

        // Run on, three ticks, each visible exactly three edges after sampling
        applyStimulus(SEL_CTRL, 56'h1);
        waitCycles(6);
        for (int i = 0; i < 3; i++) begin
            tickOnce();
            waitCycles(2);
            checkOutput("tick_early", rd_buf, {8'h01, 56'(i)});
            waitCycles(1);
            checkOutput("tick_lat3", rd_buf, {8'h01, 56'(i + 1)});
            waitCycles(7);
        end
        checkOutput("three_ticks", rd_buf, 64'h0100_0000_0000_0003);

        // Wrap from all-ones
        applyStimulus(SEL_TIME, 56'hFF_FFFF_FFFF_FFFF);
        waitCycles(6);
        checkOutput("time_set_max", rd_buf, 64'h01FF_FFFF_FFFF_FFFF);
        tickOnce();
        waitCycles(6);
        checkOutput("time_wrap", rd_buf, 64'h0100_0000_0000_0000);

        // Alarm at 5
        applyStimulus(SEL_ALARM, 56'd5);
        waitCycles(6);
        applyStimulus(SEL_CTRL, 56'h3);
        waitCycles(6);
        applyStimulus(SEL_TIME, 56'd3);
        waitCycles(6);
        tickOnce();
        waitCycles(6);
        checkOutput("alarm_pre", rd_buf, 64'h0300_0000_0000_0004);
        tickOnce();
        waitCycles(1);
        checkOutput("irq_before_tick", {63'b0, irq}, 64'h0);
        waitCycles(1);
        checkOutput("irq_at_tick", {63'b0, irq}, 64'h1);
        waitCycles(4);
        checkOutput("alarm_status", rd_buf, 64'h0700_0000_0000_0005);
        applyStimulus(SEL_CTRL, 56'h7);
        waitCycles(6);
        checkOutput("irq_cleared", {63'b0, irq}, 64'h0);
        checkOutput("irq_clr_status", rd_buf, 64'h0300_0000_0000_0005);

        // Tick and TIME write on the same edge
        tick = 1'b1; buf_dv = 1'b1; wr_buf = {SEL_TIME, 56'd100};
        @(negedge clk);
        tick = 1'b0; buf_dv = 1'b0;
        waitCycles(3);
        checkOutput("simul_time", {8'h0, rd_buf[55:0]}, 64'd100);
        waitCycles(6);
        checkOutput("simul_nolost", rd_buf, 64'h0300_0000_0000_0064);

        // Two ticks during a CTRL write service
        buf_dv = 1'b1; wr_buf = {SEL_CTRL, 56'h3};
        @(negedge clk);
        buf_dv = 1'b0; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        waitCycles(8);
        checkOutput("tick_lost", rd_buf, 64'h0B00_0000_0000_0065);
        applyStimulus(SEL_CTRL, 56'hB);
        waitCycles(6);
        checkOutput("lost_cleared", rd_buf, 64'h0300_0000_0000_0065);

        // Unknown select
        applyStimulus(8'h7F, 56'h1234);
        busy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        checkOutput("unk_busy_cycles", 64'(busy_cnt), 64'd2);
        checkOutput("unk_rd", rd_buf, 64'h0300_0000_0000_0065);

        // Reset while in TICK
        tickOnce();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rd", rd_buf, 64'h0);
        checkOutput("midrst_irq", {63'b0, irq}, 64'h0);
        checkOutput("midrst_busy", {63'b0, busy}, 64'h0);
        rst = 1'b0;
        tickOnce();
        waitCycles(5);
        checkOutput("stopped_tick", rd_buf, 64'h0);

        // Randomized traffic
        applyStimulus(SEL_CTRL, 56'h1);
        for (int c = 0; c < 3000; c++) begin
            tick = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) begin
                buf_dv = ~buf_dv;
                if (buf_dv) begin
                    r = $urandom_range(0, 9);
                    rv = 56'({$urandom, $urandom});
                    if (r == 0)      wr_buf = {SEL_TIME, rv};
                    else if (r == 1) wr_buf = {SEL_TIME, 56'hFF_FFFF_FFFF_FFFF - 56'($urandom_range(0, 3))};
                    else if (r == 2) wr_buf = {SEL_TIME, m_time};
                    else if (r <= 4) wr_buf = {SEL_ALARM, m_time + 56'($urandom_range(1, 4))};
                    else if (r <= 7) wr_buf = {SEL_CTRL, 52'(rv), 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 3) != 0)};
                    else             wr_buf = {8'($urandom_range(3, 255)), rv};
                end
            end
            @(negedge clk);
        end
        rst = 1'b0; tick = 1'b0; buf_dv = 1'b0;
        waitCycles(10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
